// File: rtl/imul_iterative.sv
// Multi-cycle shift-add multiplier returning the low nbits of a*b over val/rdy streams.
// Optional IMUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module imul_iterative #(
  parameter int unsigned nbits = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [nbits-1:0] istream_a,
  input  logic [nbits-1:0] istream_b,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [nbits-1:0] ostream_msg
);

  localparam int unsigned CntW = $clog2(nbits) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(nbits - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [nbits-1:0] a_q, a_d;
  logic [nbits-1:0] b_q, b_d;
  logic [nbits-1:0] result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             last_iter;

`ifdef IMUL_EARLY_EXIT_EN
  // Stop once the shifted multiplier holds no more set bits.
  assign last_iter = (cnt_q == CntLast) || (b_q[nbits-1:1] == '0);
`else
  assign last_iter = (cnt_q == CntLast);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (istream_val) begin
          a_d      = istream_a;
          b_d      = istream_b;
          result_d = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (b_q[0]) result_d = result_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CntW'(1);
        if (last_iter) state_d = StDone;
      end
      StDone: begin
        if (ostream_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign istream_rdy = (state_q == StIdle);
  assign ostream_val = (state_q == StDone);
  assign ostream_msg = result_q;

endmodule

// File: tb/tb_imul_iterative.sv
// Bench for imul_iterative: vector table plus hand-written corner sequences, scoreboard queue.
module tb_imul_iterative;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        istream_val = 1'b0;
  logic        istream_rdy;
  logic [31:0] istream_a = '0;
  logic [31:0] istream_b = '0;
  logic        ostream_val;
  logic        ostream_rdy = 1'b1;
  logic [31:0] ostream_msg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  imul_iterative #(.nbits(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_a   (istream_a),
    .istream_b   (istream_b),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Edges counted from the cycle the operands are presented until ostream_val is seen.
  function automatic int exp_lat(input logic [31:0] b);
`ifdef IMUL_EARLY_EXIT_EN
    int h;
    h = 0;
    for (int i = 0; i < 32; i++) if (b[i]) h = i + 1;
    return 1 + ((h < 1) ? 1 : h);
`else
    return 33;
`endif
  endfunction

  task automatic wait_done(input bit keep_val, input logic [31:0] na, input logic [31:0] nb,
                           output int lat);
    logic saw_rdy;
    saw_rdy = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        istream_val = keep_val;
        istream_a   = na;
        istream_b   = nb;
      end
      if (!ostream_val && istream_rdy) saw_rdy = 1'b1;
    end while (!ostream_val && lat < 200);
    check("busy istream_rdy", 32'(saw_rdy), 32'd0);
    if (!ostream_val) begin
      errors++;
      $display("FAIL timeout: ostream_val not seen within %0d cycles", lat);
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                       input int hold, input string name);
    int lat;
    logic [31:0] want;
    @(negedge clk);
    check({name, " idle rdy"}, 32'(istream_rdy), 32'd1);
    istream_val = 1'b1;
    istream_a   = a;
    istream_b   = b;
    ostream_rdy = (hold == 0);
    exp_q.push_back(exp);
    wait_done(1'b0, $urandom, $urandom, lat);
    check({name, " latency"}, 32'(lat), 32'(exp_lat(b)));
    want = exp_q.pop_front();
    if (ostream_val) begin
      for (int i = 0; i < hold; i++) begin
        check({name, " hold state"}, {29'd0, ostream_val, istream_rdy, 1'b0}, 32'h4);
        check({name, " hold msg"}, ostream_msg, want);
        @(negedge clk);
      end
      check({name, " msg"}, ostream_msg, want);
      ostream_rdy = 1'b1;
      @(negedge clk);
      check({name, " back to idle"}, {30'd0, ostream_val, istream_rdy}, 32'h1);
    end
  endtask

  initial begin
    int lat;
    logic saw_val;

    vecs[0] = '{32'd3,         32'd5,         32'd15,        0};
    vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  0};
    vecs[2] = '{32'h80000000,  32'd2,         32'h00000000,  0};
    vecs[3] = '{32'hFFFFFFFD,  32'd7,         32'hFFFFFFEB,  0};
    vecs[4] = '{32'd6,         32'd7,         32'd42,        10};
    vecs[5] = '{32'h12345678,  32'h10,        32'h23456780,  0};
    vecs[6] = '{32'h0000FFFF,  32'h00010001,  32'hFFFFFFFF,  3};
    vecs[7] = '{32'd1,         32'h80000000,  32'h80000000,  0};
    vecs[8] = '{32'd7,         32'd0,         32'd0,         0};

    // Asynchronous reset, asserted away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset outputs", {30'd0, istream_rdy, ostream_val}, 32'h2);
    check("reset msg", ostream_msg, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post-reset idle", {30'd0, istream_rdy, ostream_val}, 32'h2);

    for (int i = 0; i < 9; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold, $sformatf("vec%0d", i));

    // Back-to-back: istream_val stays high across two operand pairs.
    @(negedge clk);
    istream_val = 1'b1;
    istream_a   = 32'd2;
    istream_b   = 32'd9;
    ostream_rdy = 1'b1;
    exp_q.push_back(32'd18);
    wait_done(1'b1, 32'd10, 32'd0, lat);
    exp_q.push_back(32'd0);
    check("b2b first latency", 32'(lat), 32'(exp_lat(32'd9)));
    check("b2b first msg", ostream_msg, exp_q.pop_front());
    @(negedge clk);
    check("b2b idle between", {30'd0, ostream_val, istream_rdy}, 32'h1);
    wait_done(1'b0, $urandom, $urandom, lat);
    check("b2b second latency", 32'(lat), 32'(exp_lat(32'd0)));
    check("b2b second msg", ostream_msg, exp_q.pop_front());
    saw_val = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ostream_val) saw_val = 1'b1;
    end
    check("b2b no third result", 32'(saw_val), 32'd0);

    // Reset during CALC drops the operation.
    @(negedge clk);
    istream_val = 1'b1;
    istream_a   = 32'd4;
    istream_b   = 32'd4;
    @(negedge clk);
    istream_val = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid-calc reset", {30'd0, istream_rdy, ostream_val}, 32'h2);
    @(negedge clk);
    rst_n = 1'b1;
    saw_val = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ostream_val) saw_val = 1'b1;
    end
    check("dropped op silent", 32'(saw_val), 32'd0);
    do_op(32'd1, 32'd1, 32'd1, 0, "after reset");

    // Reset while holding a result in DONE clears it without a clock edge.
    @(negedge clk);
    istream_val = 1'b1;
    istream_a   = 32'd5;
    istream_b   = 32'd5;
    ostream_rdy = 1'b0;
    wait_done(1'b0, $urandom, $urandom, lat);
    check("done msg before reset", ostream_msg, 32'd25);
    #2 rst_n = 1'b0;
    #1;
    check("done reset outputs", {30'd0, istream_rdy, ostream_val}, 32'h2);
    check("done reset msg", ostream_msg, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ostream_rdy = 1'b1;
    do_op(32'd11, 32'd13, 32'd143, 0, "final");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d results never seen", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
